// File: rtl/result_monitor.sv
// On-chip checker for the 3-bit result bus of the traffic/dice multiplexer.
// Tracks the legal successor sequence per mode and records violations.
module result_monitor #(
    parameter int CNT_W    = 8,
    parameter int SYNC_LIM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             button,
    input  logic [2:0]       result,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_count,
    output logic             in_sync,
    output logic [CNT_W-1:0] roll_count
);

    localparam int SC_W = (SYNC_LIM > 1) ? $clog2(SYNC_LIM) : 1;
    localparam logic [SC_W-1:0] SYNC_MAX = SC_W'(SYNC_LIM - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Successor helpers return 3'b000 for values outside the legal set.
    function automatic logic [2:0] traffic_succ(input logic [2:0] v);
        logic [2:0] s;
        case (v)
            3'b100:  s = 3'b110;
            3'b110:  s = 3'b001;
            3'b001:  s = 3'b010;
            3'b010:  s = 3'b100;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] dice_succ(input logic [2:0] v);
        logic [2:0] s;
        case (v)
            3'd1:    s = 3'd2;
            3'd2:    s = 3'd3;
            3'd3:    s = 3'd4;
            3'd4:    s = 3'd5;
            3'd5:    s = 3'd6;
            3'd6:    s = 3'd1;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [2:0]       prev_result_q;
    logic             prev_button_q;
    logic             prev_sel_q;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] roll_count_q, roll_count_d;
    logic             in_sync_q;

    logic             legal_s;
    logic [2:0]       exp_succ_s;
    logic             viol_s;
    logic [2:0]       code_s;
    logic             roll_inc_s;

    // Next-state and violation detection for the sequence-tracking FSM.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        viol_s     = 1'b0;
        code_s     = 3'd0;
        roll_inc_s = 1'b0;
        legal_s    = sel ? (traffic_succ(result) != 3'b000) : (dice_succ(result) != 3'd0);
        exp_succ_s = sel ? traffic_succ(prev_result_q) : dice_succ(prev_result_q);

        // A mode change invalidates the history, so it pre-empts every check.
        if (sel != prev_sel_q) begin
            state_d    = ST_INIT;
            sync_cnt_d = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d    = ST_SYNC;
                    sync_cnt_d = '0;
                end
                ST_SYNC: begin
                    if (legal_s) begin
                        state_d    = ST_CHECK;
                        sync_cnt_d = '0;
                    end else if (sync_cnt_q == SYNC_MAX) begin
                        viol_s     = 1'b1;
                        code_s     = sel ? 3'd2 : 3'd5;
                        sync_cnt_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SC_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (sel) begin
                        if (result != exp_succ_s) begin
                            viol_s = 1'b1;
                            code_s = 3'd1;
                        end else begin
                            viol_s = 1'b0;
                        end
                    end else if (!prev_button_q) begin
                        if (result != prev_result_q) begin
                            viol_s = 1'b1;
                            code_s = 3'd3;
                        end else begin
                            viol_s = 1'b0;
                        end
                    end else if (result != exp_succ_s) begin
                        viol_s = 1'b1;
                        code_s = 3'd4;
                    end else begin
                        roll_inc_s = 1'b1;
                    end
                    // Re-anchor on a legal value; otherwise resynchronise.
                    if (viol_s && !legal_s) begin
                        state_d    = ST_SYNC;
                        sync_cnt_d = '0;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                default: begin
                    state_d    = ST_INIT;
                    sync_cnt_d = '0;
                end
            endcase
        end
    end

    // Error recording: sticky flag, first code kept, saturating counters.
    always_comb begin
        err_d        = err_q | viol_s;
        err_code_d   = err_code_q;
        err_count_d  = err_count_q;
        roll_count_d = roll_count_q;
        if (viol_s && !err_q) begin
            err_code_d = code_s;
        end else begin
            err_code_d = err_code_q;
        end
        if (viol_s && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
        if (roll_inc_s && !(&roll_count_q)) begin
            roll_count_d = roll_count_q + CNT_W'(1);
        end else begin
            roll_count_d = roll_count_q;
        end
    end

    // State, history and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            sync_cnt_q    <= '0;
            prev_result_q <= 3'd0;
            prev_button_q <= 1'b0;
            prev_sel_q    <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
            err_count_q   <= '0;
            roll_count_q  <= '0;
            in_sync_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            prev_result_q <= result;
            prev_button_q <= button;
            prev_sel_q    <= sel;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
            roll_count_q  <= roll_count_d;
            in_sync_q     <= (state_d == ST_CHECK);
        end
    end

    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;
    assign in_sync    = in_sync_q;
    assign roll_count = roll_count_q;

endmodule

// File: tb/tb_result_monitor.sv
// Self-checking bench for result_monitor: directed scenarios plus randomized
// traffic/dice streams compared each cycle against a behavioural model.
module tb_result_monitor;

    localparam int SYNC_LIM = 4;
    localparam int CNT_MAX  = 255;

    logic       clk = 1'b0;
    logic       rst, sel, button;
    logic [2:0] result;
    logic       err, in_sync;
    logic [2:0] err_code;
    logic [7:0] err_count, roll_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (phase: 0=init, 1=sync, 2=check).
    int m_phase, m_cnt, m_prev_res, m_prev_btn, m_prev_sel;
    int m_err, m_code, m_errcnt, m_roll;

    int tseq [4] = '{4, 6, 1, 2};

    always #5 clk = ~clk;

    result_monitor #(.CNT_W(8), .SYNC_LIM(SYNC_LIM)) dut (
        .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
        .err(err), .err_code(err_code), .err_count(err_count),
        .in_sync(in_sync), .roll_count(roll_count)
    );

    function automatic int t_succ(input int v);
        for (int i = 0; i < 4; i++) begin
            if (tseq[i] == v) return tseq[(i + 1) % 4];
        end
        return -1;
    endfunction

    function automatic int d_succ(input int v);
        if (v >= 1 && v <= 6) return (v % 6) + 1;
        return -1;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int r, input int s, input int b, input int res);
        int  exp_s, code;
        bit  legal, viol;
        if (r != 0) begin
            m_phase = 0; m_cnt = 0; m_prev_res = 0; m_prev_btn = 0; m_prev_sel = 0;
            m_err = 0; m_code = 0; m_errcnt = 0; m_roll = 0;
            return;
        end
        legal = (s != 0) ? (t_succ(res) >= 0) : (d_succ(res) >= 0);
        exp_s = (s != 0) ? t_succ(m_prev_res) : d_succ(m_prev_res);
        viol  = 1'b0;
        code  = 0;
        if (s != m_prev_sel) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_cnt   = 0;
        end else if (m_phase == 1) begin
            if (legal) begin
                m_phase = 2; m_cnt = 0;
            end else if (m_cnt == SYNC_LIM - 1) begin
                viol = 1'b1; code = (s != 0) ? 2 : 5; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (s != 0) begin
                if (res != exp_s) begin viol = 1'b1; code = 1; end
            end else if (m_prev_btn == 0) begin
                if (res != m_prev_res) begin viol = 1'b1; code = 3; end
            end else if (res != exp_s) begin
                viol = 1'b1; code = 4;
            end else if (m_roll < CNT_MAX) begin
                m_roll++;
            end
            if (viol && !legal) begin m_phase = 1; m_cnt = 0; end
        end
        if (viol) begin
            if (m_err == 0) m_code = code;
            m_err = 1;
            if (m_errcnt < CNT_MAX) m_errcnt++;
        end
        m_prev_res = res; m_prev_btn = b; m_prev_sel = s;
    endtask

    // One clock: apply inputs, advance model at the edge, compare after it.
    task automatic cycle(input int r, input int s, input int b, input int res);
        rst = r[0]; sel = s[0]; button = b[0]; result = res[2:0];
        @(posedge clk);
        model_step(r, s, b, res);
        #1;
        check_eq("err",        err,        m_err);
        check_eq("err_code",   err_code,   m_code);
        check_eq("err_count",  err_count,  m_errcnt);
        check_eq("in_sync",    in_sync,    (m_phase == 2) ? 1 : 0);
        check_eq("roll_count", roll_count, m_roll);
    endtask

    initial begin
        int v, lres, lbtn, ls, b, r, s;
        rst = 1'b1; sel = 1'b0; button = 1'b0; result = 3'd0;

        // Reset state.
        cycle(1, 0, 0, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_cnt", err_count, 0);
        check_eq("rst_sync", in_sync, 0);

        // Traffic laps: in_sync rises on the third cycle.
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 0, tseq[i % 4]);
            if (i == 1) check_eq("t1_sync2", in_sync, 0);
            if (i == 2) check_eq("t1_sync3", in_sync, 1);
        end
        check_eq("t1_err", err, 0);
        check_eq("t1_sync", in_sync, 1);

        // Traffic skip 100 -> 001.
        cycle(0, 1, 0, 4);
        cycle(0, 1, 0, 1);
        check_eq("t2_err", err, 1);
        check_eq("t2_code", err_code, 1);
        check_eq("t2_cnt", err_count, 1);
        check_eq("t2_sync", in_sync, 1);
        cycle(0, 1, 0, 2);
        check_eq("t2_cnt_b", err_count, 1);

        // Dice rolls 1..6,1,2 then hold.
        cycle(1, 0, 1, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        v = 1;
        for (int i = 0; i < 7; i++) begin
            v = d_succ(v);
            cycle(0, 0, (i == 6) ? 0 : 1, v);
        end
        check_eq("t3_roll", roll_count, 7);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 2);
        check_eq("t3_roll_hold", roll_count, 7);
        check_eq("t3_err", err, 0);

        // Dice stuck at 111.
        cycle(1, 0, 0, 7);
        cycle(0, 0, 0, 7);
        for (int i = 0; i < SYNC_LIM; i++) cycle(0, 0, 0, 7);
        check_eq("t4_code", err_code, 5);
        check_eq("t4_cnt", err_count, 1);
        check_eq("t4_sync", in_sync, 0);
        cycle(0, 0, 0, 1);
        check_eq("t4_resync", in_sync, 1);

        // Change without button, then wrong advance.
        cycle(1, 0, 0, 3);
        cycle(0, 0, 0, 3);
        cycle(0, 0, 0, 3);
        cycle(0, 0, 0, 4);
        check_eq("t5_code", err_code, 3);
        cycle(0, 0, 1, 4);
        cycle(0, 0, 1, 6);
        check_eq("t5_cnt", err_count, 2);
        check_eq("t5_code_kept", err_code, 3);

        // Mode switch suppresses checking; rst mid-run clears everything.
        cycle(0, 1, 0, 5);
        check_eq("t6_cnt", err_count, 2);
        cycle(0, 1, 0, 4);
        cycle(1, 1, 0, 4);
        check_eq("t6_err", err, 0);
        check_eq("t6_code", err_code, 0);
        check_eq("t6_cnt0", err_count, 0);
        check_eq("t6_roll", roll_count, 0);

        // Error counter saturation.
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) cycle(0, 0, 0, (i % 2 == 0) ? 2 : 1);
        check_eq("sat_err", err_count, CNT_MAX);
        check_eq("sat_code", err_code, 3);

        // Roll counter saturation.
        cycle(1, 0, 1, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        v = 1;
        for (int i = 0; i < 300; i++) begin
            v = d_succ(v);
            cycle(0, 0, 1, v);
        end
        check_eq("sat_roll", roll_count, CNT_MAX);
        check_eq("sat_roll_err", err, 0);

        // Randomized mux-like streams with occasional corruption.
        lres = 1; lbtn = 0; ls = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0) ? 1 : 0;
            s = ($urandom_range(0, 79) == 0) ? 1 - ls : ls;
            b = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) begin
                v = $urandom_range(0, 7);
            end else if (s != 0) begin
                v = (t_succ(lres) >= 0) ? t_succ(lres) : 4;
            end else if (lbtn != 0) begin
                v = (d_succ(lres) >= 0) ? d_succ(lres) : 1;
            end else begin
                v = (d_succ(lres) >= 0) ? lres : 1;
            end
            cycle(r, s, b, v);
            lres = v; lbtn = b; ls = s;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
